// File: rtl/uart_tx_fifo_if.sv
// Producer and transmitter-facing signals of uart_tx_fifo, grouped for the FIFO (slave) and its environment (master).
// ovf_clear exists only when UART_TX_FIFO_OVERFLOW_EN is defined.
interface uart_tx_fifo_if #(
   parameter int PAYLOAD_BITS = 8,
   parameter int DEPTH        = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                    wr_valid;
   logic                    wr_ready;
   logic [PAYLOAD_BITS-1:0] wr_data;
   logic [LW-1:0]           level;
   logic                    empty;
   logic                    full;
   logic                    uart_tx_en;
   logic [PAYLOAD_BITS-1:0] uart_tx_data;
   logic                    uart_tx_busy;
   logic                    overflow;
`ifdef UART_TX_FIFO_OVERFLOW_EN
   logic                    ovf_clear;
`endif

   modport slave (
      input  wr_valid, wr_data, uart_tx_busy,
`ifdef UART_TX_FIFO_OVERFLOW_EN
      input  ovf_clear,
`endif
      output wr_ready, level, empty, full, uart_tx_en, uart_tx_data, overflow
   );

   modport master (
      output wr_valid, wr_data, uart_tx_busy,
`ifdef UART_TX_FIFO_OVERFLOW_EN
      output ovf_clear,
`endif
      input  wr_ready, level, empty, full, uart_tx_en, uart_tx_data, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a uart_tx transmitter one word per busy period.
// Define UART_TX_FIFO_OVERFLOW_EN to add the sticky write-while-full flag and its ovf_clear input.
module uart_tx_fifo #(
   parameter int PAYLOAD_BITS = 8,
   parameter int DEPTH        = 16
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                  state_q;
   logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]           wptr_q, wptr_d;
   logic [AW-1:0]           rptr_q, rptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic [PAYLOAD_BITS-1:0] tx_data_q;
   logic                    tx_en_q;
   logic                    empty;
   logic                    full;
   logic                    do_wr;
   logic                    do_pop;

   assign empty  = (level_q == '0);
   assign full   = (level_q == LW'(DEPTH));
   assign do_wr  = bus.wr_valid && !full;
   assign do_pop = (state_q == IDLE) && !empty && !bus.uart_tx_busy;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_wr)  wptr_d = wptr_q + AW'(1);
      if (do_pop) rptr_d = rptr_q + AW'(1);
      case ({do_wr, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage holds no control meaning, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (!reset && do_wr) mem_q[wptr_q] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         tx_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (do_pop) begin
                  state_q   <= ISSUE;
                  tx_en_q   <= 1'b1;
                  tx_data_q <= mem_q[rptr_q];
               end
            end
            ISSUE:     state_q <= WAIT_BUSY;
            WAIT_BUSY: if (bus.uart_tx_busy)  state_q <= WAIT_DONE;
            WAIT_DONE: if (!bus.uart_tx_busy) state_q <= IDLE;
            default:   state_q <= IDLE;
         endcase
      end
   end

   assign bus.wr_ready     = !full;
   assign bus.level        = level_q;
   assign bus.empty        = empty;
   assign bus.full         = full;
   assign bus.uart_tx_en   = tx_en_q;
   assign bus.uart_tx_data = tx_data_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
   logic ovf_q;

   // A fresh write-while-full on the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset)                           ovf_q <= 1'b0;
      else if (bus.wr_valid && full)       ovf_q <= 1'b1;
      else if (bus.ovf_clear)              ovf_q <= 1'b0;
   end

   assign bus.overflow = ovf_q;
`else
   assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter busy model.
module tb_uart_tx_fifo;
   localparam int PB       = 8;
   localparam int DEPTH    = 16;
   localparam int BUSY_LEN = 20;
   localparam int LIMIT    = 1500;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) bus();

   uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic busy_m    = 1'b0;
   logic hold_busy = 1'b0;
   logic arm       = 1'b0;
   logic en_prev   = 1'b0;
   int   bcnt      = 0;
   int   n_strobe  = 0;
   int   total     = 0;
   int   bad       = 0;
   logic [PB-1:0] sb [$];

   assign bus.uart_tx_busy = busy_m | hold_busy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Transmitter model: busy rises one cycle after en is seen, lasts BUSY_LEN cycles.
   always @(negedge clk) begin
      if (bus.uart_tx_en) begin
         n_strobe++;
         chk("en_one_cycle", en_prev, 0);
         chk("no_en_while_busy", busy_m, 0);
         chk("sb_nonempty_at_en", sb.size() > 0, 1);
         if (sb.size() > 0) chk("tx_data", bus.uart_tx_data, sb.pop_front());
      end
      en_prev = bus.uart_tx_en;
      if (arm) begin
         busy_m = 1'b1;
         bcnt   = BUSY_LEN;
         arm    = 1'b0;
      end else if (busy_m) begin
         bcnt--;
         if (bcnt == 0) busy_m = 1'b0;
      end
      if (bus.uart_tx_en) arm = 1'b1;
   end

   // Called at a negedge; returns at the following negedge.
   task automatic write_word(input logic [PB-1:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      if (bus.wr_ready) sb.push_back(d);
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (k < LIMIT && !(busy_m == 1'b0 && arm == 1'b0 && bus.empty && !bus.uart_tx_en)) begin
         @(negedge clk);
         k++;
      end
      chk(tag, k < LIMIT, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int base;
      int k;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h77;
`ifdef UART_TX_FIFO_OVERFLOW_EN
      bus.ovf_clear = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_level", bus.level, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_wr_ready", bus.wr_ready, 1);
      chk("rst_en", bus.uart_tx_en, 0);
      chk("rst_data", bus.uart_tx_data, 0);
      chk("rst_overflow", bus.overflow, 0);
      reset = 1'b0;
      bus.wr_valid = 1'b0;
      @(negedge clk);

      // single word and write-to-strobe latency
      write_word(8'hA5);
      chk("lat_en_early", bus.uart_tx_en, 0);
      chk("lat_level1", bus.level, 1);
      @(negedge clk);
      chk("lat_en", bus.uart_tx_en, 1);
      chk("lat_data", bus.uart_tx_data, 8'hA5);
      chk("lat_level0", bus.level, 0);
      @(negedge clk);
      chk("lat_en_drop", bus.uart_tx_en, 0);
      wait_idle("single_idle");
      chk("single_level", bus.level, 0);
      chk("single_data_held", bus.uart_tx_data, 8'hA5);

      // burst to full, then overflow attempt
      hold_busy = 1'b1;
      base = n_strobe;
      for (int i = 0; i < DEPTH; i++) write_word(PB'(i));
      chk("burst_full", bus.full, 1);
      chk("burst_wr_ready", bus.wr_ready, 0);
      chk("burst_level", bus.level, DEPTH);
      chk("burst_empty", bus.empty, 0);
      write_word(8'hFF);
      chk("ovf_level", bus.level, DEPTH);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      chk("ovf_set", bus.overflow, 1);
      bus.ovf_clear = 1'b1;
      @(negedge clk);
      bus.ovf_clear = 1'b0;
      chk("ovf_cleared", bus.overflow, 0);
`else
      chk("ovf_tied", bus.overflow, 0);
`endif
      hold_busy = 1'b0;
      wait_idle("burst_idle");
      chk("burst_strobes", n_strobe - base, DEPTH);
      chk("burst_sb_empty", sb.size(), 0);
      chk("burst_level0", bus.level, 0);

      // write and pop on the same edge with one word stored
      hold_busy = 1'b1;
      write_word(8'h11);
      chk("sim_pre_level", bus.level, 1);
      chk("sim_pre_en", bus.uart_tx_en, 0);
      hold_busy = 1'b0;
      write_word(8'h3C);
      chk("sim_level", bus.level, 1);
      chk("sim_en", bus.uart_tx_en, 1);
      chk("sim_data", bus.uart_tx_data, 8'h11);
      wait_idle("sim_idle");
      chk("sim_sb_empty", sb.size(), 0);
      chk("sim_data_last", bus.uart_tx_data, 8'h3C);

      // reset while waiting for the transmitter with words queued
      hold_busy = 1'b1;
      for (int i = 0; i < 6; i++) write_word(8'h50 + PB'(i));
      hold_busy = 1'b0;
      k = 0;
      while (k < LIMIT && !busy_m) begin
         @(negedge clk);
         k++;
      end
      chk("mid_busy_seen", k < LIMIT, 1);
      repeat (2) @(negedge clk);
      chk("mid_level5", bus.level, 5);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_level", bus.level, 0);
      chk("mid_rst_empty", bus.empty, 1);
      chk("mid_rst_en", bus.uart_tx_en, 0);
      chk("mid_rst_data", bus.uart_tx_data, 0);
      reset = 1'b0;
      base = n_strobe;
      k = 0;
      while (k < LIMIT && busy_m) begin
         @(negedge clk);
         k++;
      end
      chk("mid_busy_fell", k < LIMIT, 1);
      repeat (10) @(negedge clk);
      chk("mid_no_en", n_strobe - base, 0);
      chk("mid_level_after", bus.level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
